// File: rtl/ball_motion.sv
// ball_motion: latches serve parameters from the serve randomiser, integrates
// the ball position in 11.4 fixed point once per frame tick, reflects off the
// top/bottom walls, negates vx on paddle hits and reports left/right misses.
// Optional feature macro: BALL_SPIN_EN (adds the signed spin field to vy on
// every frame tick, saturating to [-128, 127]).

module ball_motion #(
    parameter int unsigned X_MIN = 0,
    parameter int unsigned X_MAX = 639,
    parameter int unsigned Y_MIN = 0,
    parameter int unsigned Y_MAX = 479
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        serve,
    input  logic        frame_tick,
    input  logic        paddle_hit,
    input  logic [21:0] ball_location,
    input  logic [15:0] ball_velocity,
    input  logic [15:0] ball_angle,
    output logic        rand_en,
    output logic        ball_valid,
    output logic [10:0] pos_x,
    output logic [10:0] pos_y,
    output logic        miss_left,
    output logic        miss_right
);

    localparam int unsigned PW = 15;  // 11.4 fixed-point position width
    localparam int unsigned NW = 17;  // signed width of the position step
    localparam int unsigned VW = 8;   // velocity component width
    localparam int unsigned FB = 4;   // fractional bits

    // Playfield limits scaled into fixed point.
    localparam logic signed [NW-1:0] X_LO  = NW'(X_MIN << FB);
    localparam logic signed [NW-1:0] X_HI  = NW'(X_MAX << FB);
    localparam logic signed [NW-1:0] Y_LO  = NW'(Y_MIN << FB);
    localparam logic signed [NW-1:0] Y_HI  = NW'(Y_MAX << FB);
    localparam logic signed [NW-1:0] Y_LO2 = NW'((2 * Y_MIN) << FB);
    localparam logic signed [NW-1:0] Y_HI2 = NW'((2 * Y_MAX) << FB);

    typedef enum logic {
        IDLE = 1'b0,
        FLY  = 1'b1
    } state_t;

    state_t                 state, state_n;
    logic [PW-1:0]          px, px_n;
    logic [PW-1:0]          py, py_n;
    logic signed [VW-1:0]   vx, vx_n;
    logic signed [VW-1:0]   vy, vy_n;
    logic                   rand_en_n;
    logic                   ball_valid_n;
    logic                   miss_left_n;
    logic                   miss_right_n;

    // Datapath intermediates for one frame step.
    logic signed [VW-1:0]   vx_hit;
    logic signed [VW-1:0]   vy_step;
    logic signed [NW-1:0]   nx;
    logic signed [NW-1:0]   ny;
    logic signed [NW-1:0]   ry_hi;
    logic signed [NW-1:0]   ry_lo;
    logic                   hit_left;
    logic                   hit_right;
    logic                   wall_hi;
    logic                   wall_lo;

    // Negation that maps -128 to +127 instead of wrapping back to -128.
    function automatic logic signed [VW-1:0] neg_sat(input logic signed [VW-1:0] v);
        if (v == -VW'(128)) begin
            return VW'(127);
        end
        return -v;
    endfunction

`ifdef BALL_SPIN_EN
    localparam int unsigned SW = 4;   // spin field width

    logic signed [SW-1:0]   spin, spin_n;

    // Saturating add of the 4-bit spin to an 8-bit velocity.
    function automatic logic signed [VW-1:0] add_sat(input logic signed [VW-1:0] v,
                                                     input logic signed [SW-1:0] s);
        logic signed [VW:0] sum;
        sum = {v[VW-1], v} + {{(VW+1-SW){s[SW-1]}}, s};
        if (sum > 9'sd127) begin
            return VW'(127);
        end
        if (sum < -9'sd128) begin
            return -VW'(128);
        end
        return sum[VW-1:0];
    endfunction

    wire unused_angle = ^ball_angle[11:0];

    // Spin curves the trajectory before the position step.
    always_comb begin
        vy_step = add_sat(vy, spin);
    end

    // Spin is latched on serve and held for the whole flight.
    always_comb begin
        spin_n = spin;
        if (state == IDLE && serve) begin
            spin_n = $signed(ball_angle[15:12]);
        end
    end

    // Spin register.
    always_ff @(posedge clk) begin
        if (rst) begin
            spin <= '0;
        end else begin
            spin <= spin_n;
        end
    end
`else
    wire unused_angle = ^ball_angle;

    // Without spin, vy only changes on wall reflection.
    always_comb begin
        vy_step = vy;
    end
`endif

    // One frame step: hit negation first, then position and bound tests.
    always_comb begin
        vx_hit    = paddle_hit ? neg_sat(vx) : vx;
        nx        = $signed({2'b00, px}) + $signed({{(NW-VW){vx_hit[VW-1]}}, vx_hit});
        ny        = $signed({2'b00, py}) + $signed({{(NW-VW){vy_step[VW-1]}}, vy_step});
        ry_hi     = Y_HI2 - ny;
        ry_lo     = Y_LO2 - ny;
        hit_left  = (nx < X_LO);
        hit_right = (nx > X_HI);
        wall_hi   = (ny > Y_HI);
        wall_lo   = (ny < Y_LO);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        px_n         = px;
        py_n         = py;
        vx_n         = vx;
        vy_n         = vy;
        miss_left_n  = 1'b0;
        miss_right_n = 1'b0;

        case (state)
            IDLE: begin
                if (serve) begin
                    px_n    = {ball_location[21:11], 4'b0000};
                    py_n    = {ball_location[10:0], 4'b0000};
                    vx_n    = $signed(ball_velocity[15:8]);
                    vy_n    = $signed(ball_velocity[7:0]);
                    state_n = FLY;
                end
            end
            FLY: begin
                if (paddle_hit) begin
                    vx_n = vx_hit;
                end
                if (frame_tick) begin
                    vy_n = vy_step;
                    if (hit_left) begin
                        miss_left_n = 1'b1;
                        state_n     = IDLE;
                    end else if (hit_right) begin
                        miss_right_n = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        px_n = nx[PW-1:0];
                        if (wall_hi) begin
                            py_n = ry_hi[PW-1:0];
                            vy_n = neg_sat(vy_step);
                        end else if (wall_lo) begin
                            py_n = ry_lo[PW-1:0];
                            vy_n = neg_sat(vy_step);
                        end else begin
                            py_n = ny[PW-1:0];
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        ball_valid_n = (state_n == FLY);
        rand_en_n    = (state_n == IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            px         <= '0;
            py         <= '0;
            vx         <= '0;
            vy         <= '0;
            rand_en    <= 1'b0;
            ball_valid <= 1'b0;
            miss_left  <= 1'b0;
            miss_right <= 1'b0;
        end else begin
            state      <= state_n;
            px         <= px_n;
            py         <= py_n;
            vx         <= vx_n;
            vy         <= vy_n;
            rand_en    <= rand_en_n;
            ball_valid <= ball_valid_n;
            miss_left  <= miss_left_n;
            miss_right <= miss_right_n;
        end
    end

    assign pos_x = px[PW-1:FB];
    assign pos_y = py[PW-1:FB];

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Downstream consumer of the serve randomiser's ball_location / ball_velocity / ball_angle outputs.
- Latches the serve parameters on a serve request, then integrates ball position once per video frame tick.
- Reflects the ball off the top and bottom table walls, flips direction on paddle hits, and reports misses past the left or right edge.
- Drives the randomiser's en input and feeds pixel coordinates to the renderer and scoring logic.

Parameters:
- X_MIN, 0, left playfield bound in pixels; ball x below this is a miss.
- X_MAX, 639, right playfield bound in pixels.
- Y_MIN, 0, top wall in pixels.
- Y_MAX, 479, bottom wall in pixels.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- serve  in  1  single-cycle pulse requesting a new serve.
- frame_tick  in  1  single-cycle pulse, once per frame.
- paddle_hit  in  1  single-cycle pulse; a paddle touched the ball.
- ball_location  in  22  {x[21:11], y[10:0]}, whole pixels.
- ball_velocity  in  16  {vx[15:8], vy[7:0]}, each two's complement, units of 1/16 pixel per frame.
- ball_angle  in  16  {spin[15:12] signed, reserved[11:0]}.
- rand_en  out  1  enable to the randomiser; high while idle.
- ball_valid  out  1  ball is in flight.
- pos_x  out  11  ball x in pixels.
- pos_y  out  11  ball y in pixels.
- miss_left  out  1  one-cycle pulse when the ball exits left.
- miss_right  out  1  one-cycle pulse when the ball exits right.

Behaviour:
- States: IDLE, FLY. Reset, or rst asserted at any time including mid-flight, forces IDLE.
- Reset values of all outputs are 0, including rand_en.
- rand_en is a registered copy of (state==IDLE). It rises 1 cycle after reset is released.
- Internal position registers px and py are 15-bit unsigned 11.4 fixed point. pos_x = px[14:4] and pos_y = py[14:4].
- IDLE, serve=1: on the next edge load px={x,4'b0}, py={y,4'b0}, vx, vy, spin.
  - Same edge: state becomes FLY, ball_valid=1, rand_en=0.
  - serve is ignored while in FLY.
- FLY, paddle_hit=1: vx <= -vx. Negating -128 saturates to +127.
- FLY, frame_tick=1, in this order:
  1. Spin step (only when BALL_SPIN_EN is defined): vy' = sat8(vy + sext(spin)).
  2. Position step: compute nx = px + sext(vx') and ny = py + sext(vy') in 17-bit signed arithmetic.
     - vx' is the post-hit vx when paddle_hit coincides with the tick, so negation happens first and the step uses the new sign.
- Miss check, using the limits scaled to fixed point (X_MIN<<4, X_MAX<<4):
  - nx < X_MIN<<4: miss_left pulses for 1 cycle, state becomes IDLE, ball_valid=0.
  - nx > X_MAX<<4: miss_right pulses for 1 cycle, state becomes IDLE, ball_valid=0.
  - On a miss, px and py hold their pre-step values.
  - A miss has priority over any wall reflection in the same tick.
- Wall check, using the limits scaled to fixed point (Y_MIN<<4, Y_MAX<<4):
  - ny > Y_MAX<<4: py = 2*(Y_MAX<<4) - ny and vy = -vy'.
  - ny < Y_MIN<<4: py = 2*(Y_MIN<<4) - ny and vy = -vy'.
  - Only one reflection is applied per tick, since |vy| < 8 px.
  - In all other cases py = ny.
- px = nx when there is no miss.
- A frame_tick or paddle_hit in IDLE has no effect.
- Outputs are registered, with 1-cycle latency from the triggering edge.
- miss_left and miss_right are never high simultaneously.

Optional Feature:
- Macro: BALL_SPIN_EN.
- Defined: the spin field is added to vy each frame tick, saturating to [-128, 127], which curves the trajectory.
- Undefined: ball_angle is unused and vy changes only on wall reflection.

Test Plan:
- Reset: hold rst for 3 cycles, then release → all outputs 0 during reset; 1 cycle after release rand_en=1 and ball_valid=0.
- Straight flight: serve with x=320, y=240, vx=+32, vy=+16, spin=0, then 3 frame_ticks → pos=(326,243), ball_valid=1, rand_en=0.
- Bottom wall: serve at y=478, vy=+48, then 1 tick → pos_y=477 and vy=-48; next tick → pos_y=474.
- Right miss: serve at x=638, vx=+32, then 1 tick → miss_right=1 for exactly 1 cycle, then ball_valid=0 and rand_en=1. A serve pulse issued during the flight is ignored.
- Hit with simultaneous tick: serve at x=100, vx=+32, then paddle_hit and frame_tick in the same cycle → pos_x=98 and vx=-32. Also serve with vx=-128 and apply paddle_hit → vx=+127.
- Spin: serve with vy=0 and spin=+2, then 2 ticks → with BALL_SPIN_EN, vy=4 and pos_y = y0 + 0 (6/16 px accumulated, fractional only); with a 3rd tick, vy=6 and pos_y = y0 + 0 (12/16 px accumulated). Without the macro, vy stays 0 and pos_y is unchanged.
